mul_div_unit: RTL and testbench
===============================

# mul_div_unit

Multi-cycle 32-bit unsigned multiply/divide unit in the ALU execute stage. It runs shift-add multiplication and restoring division over 32 iterations. Its `result` drives the `b` input of the ALU result 2:1 selector, which picks between the single-cycle ALU output and this unit's output. Control is a start/busy/done handshake with the pipeline control.

## Interface
- `WIDTH`, 32, operand and result width; only 32 is supported.
- `clk  input  1  rising-edge clock`
- `rst_n  input  1  reset; one clock; reset is asynchronous and active-low`
- `start  input  1  request pulse; sampled only in IDLE`
- `op  input  2  00 MUL (low word), 01 MULH (high word), 10 DIVU quotient, 11 REMU remainder`
- `a  input  32  multiplicand / dividend, sampled on accepted start`
- `b  input  32  multiplier / divisor, sampled on accepted start`
- `busy  output  1  high from the cycle after accept until the done cycle, exclusive`
- `done  output  1  single-cycle pulse; result valid from this cycle`
- `result  output  32  final value, held until the next accepted start`
- `dz  output  1  divide-by-zero flag, valid with done, held with result`

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - When `start=1`, latch `a`, `b` and `op`, clear the 64-bit accumulator and set the 6-bit counter to 0.
  - If `op[1]=1` and `b==0`, go to DONE. Otherwise go to RUN.
- RUN:
  - One iteration per cycle and the counter increments.
  - When the counter reaches 31, go to DONE after that iteration.
- DONE:
  - Drive `done=1` and load `result` and `dz`, then return to IDLE.
- MUL/MULH:
  - Each iteration: if the multiplier LSB is 1, add the multiplicand to the upper half of the 64-bit product. Then shift the product right by 1 with the 33-bit sum carry.
  - MUL returns product[31:0]; MULH returns product[63:32].
- DIVU/REMU:
  - Each iteration: shift {remainder, quotient} left by 1, then compute a 33-bit trial subtraction of the divisor.
  - If the trial result is non-negative, keep the subtraction and set quotient LSB to 1.
- Divide by zero:
  - DIVU returns 0xFFFFFFFF and REMU returns the dividend `a`.
  - `dz=1`; it is 0 for every other operation.
- `start` while `busy` or in DONE: ignored, with no effect on the operation in flight.
- Input changes after accept: ignored, because operands are latched.
- Reset, asynchronous and at any time including mid-operation:
  - State goes to IDLE.
  - `busy=0`, `done=0`, `result=0`, `dz=0`, counter 0, accumulators 0.

## Timing
- Accept at cycle 0, which is the edge where `start=1` in IDLE.
- `busy=1` during cycles 1..32.
- `done=1` at cycle 33 for MUL, MULH, and DIVU/REMU with nonzero divisor.
- Divide by zero: `done=1` at cycle 1, and `busy` never rises.
- Earliest next accept: the cycle after `done` (IDLE), giving back-to-back throughput of one op per 34 cycles.
- `result`/`dz` are registered outputs with no combinational path from inputs.

## Configuration
- `MULDIV_DIV_EN`, when defined: the divider datapath and DIVU/REMU are implemented as above.
- When undefined: the divider logic is removed.
  - `op=10`/`11` goes straight to DONE: `done` at cycle 1, `result=0`, `dz=0`.
  - MUL/MULH are unaffected.

## Structure
- Shared package `muldiv_pkg` holds:
  - op encodings `OP_MUL`, `OP_MULH`, `OP_DIVU`, `OP_REMU`;
  - FSM state enum `IDLE`/`RUN`/`DONE`;
  - constant `MULDIV_ITERS = 32`;
  - the divide-by-zero quotient constant 0xFFFFFFFF.
- One sub-module, `muldiv_ctrl`: FSM plus iteration counter, emitting `load`, `step`, `finish`, `busy` and `done`.
- The shift/add/subtract datapath stays in `mul_div_unit`.

## Test plan
- MUL a=7, b=6 -> `done` at cycle 33, `result=42`, `dz=0`.
- MULH a=0xFFFFFFFF, b=0xFFFFFFFF -> `result=0xFFFFFFFE`; MUL on the same operands -> `0x00000001`.
- DIVU a=100, b=7 -> `result=14`; REMU same operands -> `result=2`; both with `done` at cycle 33.
- DIVU a=5, b=0 -> `done` at cycle 1, `result=0xFFFFFFFF`, `dz=1`; REMU a=5, b=0 -> `result=5`, `dz=1`.
- MUL 3×4, re-assert `start` with MUL 9×9 at cycle 10 -> still `result=12` at cycle 33; second start ignored.
- MUL 3×4, assert `rst_n=0` at cycle 15 -> immediately `busy=0`, `result=0`, no `done` pulse. A fresh MUL 3×4 after reset -> `done` 33 cycles after accept, `result=12`.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings and constants for the iterative multiply/divide unit.
package muldiv_pkg;

    localparam int MULDIV_ITERS = 32;

    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_MULH = 2'b01;
    localparam logic [1:0] OP_DIVU = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    localparam logic [31:0] DZ_QUOT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/muldiv_ctrl.sv
// Purpose: sequencing FSM and iteration counter for mul_div_unit.
// Latency: accept -> 32 step cycles -> done pulse; skip path goes accept -> done.
// Backpressure: none; start is only honoured in IDLE, ignored otherwise.
module muldiv_ctrl
    import muldiv_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic skip,
    output logic load,
    output logic step,
    output logic finish,
    output logic busy,
    output logic done
);

    state_e     state;
    state_e     state_nxt;
    logic [5:0] cnt;
    logic       last;

    assign last = (cnt == 6'(MULDIV_ITERS - 1));

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load = 1'b1;
                    if (skip) begin
                        finish    = 1'b1;
                        state_nxt = DONE;
                    end else begin
                        state_nxt = RUN;
                    end
                end
            end
            RUN: begin
                step = 1'b1;
                if (last) begin
                    finish    = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (load)
                cnt <= '0;
            else if (step)
                cnt <= cnt + 6'd1;
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: rtl/mul_div_unit.sv
// Purpose: 32-bit unsigned shift-add multiply / restoring divide; divider present only with MULDIV_DIV_EN.
// Latency: done 33 cycles after accept; divide-by-zero or disabled divide finishes 1 cycle after accept.
// Backpressure: start ignored while busy or done; operands latched on accept.
module mul_div_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             dz
);

    logic               load;
    logic               step;
    logic               finish;
    logic               skip;
    logic               hi_q;
    logic [WIDTH-1:0]   opnd_q;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [WIDTH:0]     sum;

`ifdef MULDIV_DIV_EN
    logic               div_q;
    logic [WIDTH:0]     trial;
    assign skip = op[1] && (b == '0);
`else
    assign skip = op[1];
`endif

    muldiv_ctrl u_ctrl (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .skip   (skip),
        .load   (load),
        .step   (step),
        .finish (finish),
        .busy   (busy),
        .done   (done)
    );

    // acc holds {product_hi, multiplier} for MUL, {remainder, quotient} for DIV
    always_comb begin
        sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd_q} : '0);
        acc_nxt = {sum, acc[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
        // acc[63] set means the shifted remainder already exceeds any 32-bit divisor
        trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_q};
        if (div_q) begin
            if (acc[2*WIDTH-1] || !trial[WIDTH])
                acc_nxt = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            else
                acc_nxt = {acc[2*WIDTH-2:0], 1'b0};
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            opnd_q <= '0;
            hi_q   <= 1'b0;
`ifdef MULDIV_DIV_EN
            div_q  <= 1'b0;
`endif
        end else if (load) begin
            acc    <= {{WIDTH{1'b0}}, (op[1] ? a : b)};
            opnd_q <= op[1] ? b : a;
            hi_q   <= op[0];
`ifdef MULDIV_DIV_EN
            div_q  <= op[1];
`endif
        end else if (step) begin
            acc <= acc_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result <= '0;
            dz     <= 1'b0;
        end else if (finish) begin
            if (step) begin
                result <= hi_q ? acc_nxt[2*WIDTH-1:WIDTH] : acc_nxt[WIDTH-1:0];
                dz     <= 1'b0;
            end else begin
`ifdef MULDIV_DIV_EN
                result <= op[0] ? a : DZ_QUOT;
                dz     <= 1'b1;
`else
                result <= '0;
                dz     <= 1'b0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed + random scoreboard bench for mul_div_unit; expectations follow MULDIV_DIV_EN.
module tb_mul_div_unit;
    import muldiv_pkg::*;

`ifdef MULDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    typedef struct {
        logic [31:0] res;
        logic        dz;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        dz;

    exp_t sb[$];
    int   ncomp = 0;
    int   nfail = 0;

    always #5 clk = ~clk;

    mul_div_unit #(.WIDTH(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .dz     (dz)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncomp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        exp_t        e;
        logic [63:0] p;
        p     = {32'h0, x} * {32'h0, y};
        e.dz  = 1'b0;
        e.lat = 33;
        case (o)
            OP_MUL:  e.res = p[31:0];
            OP_MULH: e.res = p[63:32];
            default: begin
                if (!DIV_EN) begin
                    e.res = 32'h0;
                    e.lat = 1;
                end else if (y == 32'h0) begin
                    e.res = (o == OP_DIVU) ? 32'hFFFF_FFFF : x;
                    e.dz  = 1'b1;
                    e.lat = 1;
                end else begin
                    e.res = (o == OP_DIVU) ? x / y : x % y;
                end
            end
        endcase
        return e;
    endfunction

    // poke_at > 0: re-assert start (MUL 9x9) at that cycle; rst_at > 0: reset at that cycle
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] eres, input logic edz, input int elat,
                          input int poke_at, input int rst_at);
        exp_t e;
        int   n;
        int   bcnt;
        int   dcnt;
        bit   seen;
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        if (rst_at <= 0) begin
            e.res = eres;
            e.dz  = edz;
            e.lat = elat;
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        op    = 2'($urandom);
        a     = $urandom;
        b     = $urandom;
        n     = 1;
        bcnt  = 0;
        seen  = 1'b0;
        while (!seen && n <= 60) begin
            if (poke_at > 0 && n == poke_at) begin
                start = 1'b1;
                op    = OP_MUL;
                a     = 32'd9;
                b     = 32'd9;
            end else if (poke_at > 0 && n == poke_at + 1) begin
                start = 1'b0;
            end
            if (n == rst_at) begin
                rst_n = 1'b0;
                #1;
                check("rst_busy", busy, 0);
                check("rst_done", done, 0);
                check("rst_result", result, 0);
                check("rst_dz", dz, 0);
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
                dcnt  = 0;
                repeat (40) begin
                    @(negedge clk);
                    if (done) dcnt++;
                end
                check("rst_no_done", dcnt, 0);
                return;
            end
            if (done) begin
                seen = 1'b1;
                e    = sb.pop_front();
                check("latency", n, e.lat);
                check("result", result, e.res);
                check("dz", dz, e.dz);
                check("busy_at_done", busy, 0);
                check("busy_cycles", bcnt, (e.lat == 33) ? 32 : 0);
            end else begin
                if (busy) bcnt++;
                @(negedge clk);
                n++;
            end
        end
        if (!seen) begin
            ncomp++;
            nfail++;
            $error("FAIL done_timeout observed=no_done expected=done");
            if (sb.size() > 0) void'(sb.pop_front());
        end else begin
            @(negedge clk);
            check("done_pulse", done, 0);
            check("result_hold", result, e.res);
        end
    endtask

    initial begin
        exp_t        m;
        logic [1:0]  ro;
        logic [31:0] rx;
        logic [31:0] ry;
        rst_n = 1'b0;
        start = 1'b0;
        op    = 2'b00;
        a     = 32'h0;
        b     = 32'h0;
        #12;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_result", result, 0);
        check("reset_dz", dz, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(OP_MUL,  32'd7, 32'd6, 32'd42, 1'b0, 33, -1, -1);
        run_op(OP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 33, -1, -1);
        run_op(OP_MUL,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 33, -1, -1);
        run_op(OP_DIVU, 32'd100, 32'd7, DIV_EN ? 32'd14 : 32'd0, 1'b0, DIV_EN ? 33 : 1, -1, -1);
        run_op(OP_REMU, 32'd100, 32'd7, DIV_EN ? 32'd2 : 32'd0, 1'b0, DIV_EN ? 33 : 1, -1, -1);
        run_op(OP_DIVU, 32'd5, 32'd0, DIV_EN ? 32'hFFFF_FFFF : 32'd0, DIV_EN, 1, -1, -1);
        run_op(OP_REMU, 32'd5, 32'd0, DIV_EN ? 32'd5 : 32'd0, DIV_EN, 1, -1, -1);
        run_op(OP_MUL,  32'd3, 32'd4, 32'd12, 1'b0, 33, 10, -1);
        run_op(OP_MUL,  32'd3, 32'd4, 32'd0, 1'b0, 0, -1, 15);
        run_op(OP_MUL,  32'd3, 32'd4, 32'd12, 1'b0, 33, -1, -1);

        for (int i = 0; i < 8; i++) begin
            ro = 2'(i % 4);
            rx = $urandom;
            ry = (i >= 4) ? 32'($urandom_range(1, 1000)) : $urandom;
            m  = model(ro, rx, ry);
            run_op(ro, rx, ry, m.res, m.dz, m.lat, -1, -1);
        end

        check("scoreboard_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
        $finish;
    end

endmodule
